// File: rtl/inst_mem_loader.sv
// Byte-stream programmer for the core's instruction memory: parses a length-prefixed
// little-endian stream, writes words to offsets 0..N-1, pulses done, then captures the result.
module inst_mem_loader #(
  parameter int INST_MEM_ADDR_SIZE = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    byte_in,
  input  logic                          byte_valid,
  output logic                          byte_ready,
  output logic [31:0]                   inst,
  output logic [INST_MEM_ADDR_SIZE-1:0] inst_mem_offset,
  output logic                          programming_data_valid,
  output logic                          programming_done,
  input  logic                          result_valid,
  input  logic                          result_passed,
  output logic                          busy,
  output logic                          load_error,
  output logic                          status_valid,
  output logic                          status_pass
);

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    DONE,
    RUN,
    ERROR
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'd1 << INST_MEM_ADDR_SIZE;

  state_t                      state_q, state_d;
  logic [15:0]                 len_q;
  logic [1:0]                  idx_q;
  logic [INST_MEM_ADDR_SIZE:0] word_cnt_q;
  logic [23:0]                 asm_q;

  logic        xfer;
  logic [15:0] hdr_len;
  logic        hdr_ok;
  logic        last_word;

  assign xfer      = byte_valid && byte_ready;
  assign hdr_len   = {byte_in, len_q[7:0]};
  assign hdr_ok    = (hdr_len != 16'd0) && ({1'b0, hdr_len} <= MAX_WORDS);
  // The counter is one bit wider than the offset so N = 2**ADDR terminates without wrapping.
  assign last_word = (17'(word_cnt_q) + 17'd1) == {1'b0, len_q};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= LEN_LO;
    else       state_q <= state_d;
  end

  // NOTE: defaulting state_d first keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LEN_LO:  if (xfer) state_d = LEN_HI;
      LEN_HI:  if (xfer) state_d = hdr_ok ? DATA : ERROR;
      DATA:    if (xfer && idx_q == 2'd3) state_d = WRITE;
      WRITE:   state_d = last_word ? DONE : DATA;
      DONE:    state_d = RUN;
      RUN:     state_d = RUN;
      ERROR:   state_d = ERROR;
      default: state_d = LEN_LO;
    endcase
  end

  // All handshake and strobe outputs decode the registered state only.
  always_comb begin
    byte_ready             = 1'b0;
    programming_data_valid = 1'b0;
    programming_done       = 1'b0;
    busy                   = 1'b0;
    load_error             = 1'b0;
    unique case (state_q)
      LEN_LO:  byte_ready = 1'b1;
      LEN_HI:  begin byte_ready = 1'b1; busy = 1'b1; end
      DATA:    begin byte_ready = 1'b1; busy = 1'b1; end
      WRITE:   begin programming_data_valid = 1'b1; busy = 1'b1; end
      DONE:    begin programming_done = 1'b1; busy = 1'b1; end
      RUN:     ;
      ERROR:   load_error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q           <= '0;
      idx_q           <= '0;
      word_cnt_q      <= '0;
      asm_q           <= '0;
      inst            <= '0;
      inst_mem_offset <= '0;
      status_valid    <= 1'b0;
      status_pass     <= 1'b0;
    end else begin
      unique case (state_q)
        LEN_LO: if (xfer) len_q[7:0] <= byte_in;
        LEN_HI: if (xfer) begin
          len_q[15:8] <= byte_in;
          idx_q       <= '0;
          word_cnt_q  <= '0;
        end
        DATA: if (xfer) begin
          idx_q <= idx_q + 2'd1;
          // The top byte goes straight to inst so the word is presented in the WRITE cycle.
          unique case (idx_q)
            2'd0: asm_q[7:0]   <= byte_in;
            2'd1: asm_q[15:8]  <= byte_in;
            2'd2: asm_q[23:16] <= byte_in;
            2'd3: begin
              inst            <= {byte_in, asm_q};
              inst_mem_offset <= word_cnt_q[INST_MEM_ADDR_SIZE-1:0];
            end
            default: ;
          endcase
        end
        WRITE: word_cnt_q <= word_cnt_q + 1'b1;
        RUN: if (result_valid && !status_valid) begin
          status_valid <= 1'b1;
          status_pass  <= result_passed;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: basic load, header errors, full-size load,
// stalled stream, result capture and reset mid-load.
module tb_inst_mem_loader;

  localparam int ADDR = 10;

  logic            clk = 1'b0;
  logic            reset;
  logic [7:0]      byte_in;
  logic            byte_valid;
  logic            byte_ready;
  logic [31:0]     inst;
  logic [ADDR-1:0] inst_mem_offset;
  logic            programming_data_valid;
  logic            programming_done;
  logic            result_valid;
  logic            result_passed;
  logic            busy;
  logic            load_error;
  logic            status_valid;
  logic            status_pass;

  inst_mem_loader #(.INST_MEM_ADDR_SIZE(ADDR)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .byte_in                (byte_in),
    .byte_valid             (byte_valid),
    .byte_ready             (byte_ready),
    .inst                   (inst),
    .inst_mem_offset        (inst_mem_offset),
    .programming_data_valid (programming_data_valid),
    .programming_done       (programming_done),
    .result_valid           (result_valid),
    .result_passed          (result_passed),
    .busy                   (busy),
    .load_error             (load_error),
    .status_valid           (status_valid),
    .status_pass            (status_pass)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Write/done log sampled on the falling edge.
  logic [31:0] wr_data[$];
  int          wr_off[$];
  int          wr_cyc[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          overlap_cnt = 0;
  int          back2back_cnt = 0;
  logic        prev_pdv = 1'b0;
  logic        prev_done = 1'b0;

  always @(negedge clk) begin
    if (programming_data_valid === 1'b1) begin
      wr_data.push_back(inst);
      wr_off.push_back(int'(inst_mem_offset));
      wr_cyc.push_back(cyc);
    end
    if (programming_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (programming_data_valid === 1'b1 && programming_done === 1'b1) overlap_cnt++;
    if ((programming_data_valid === 1'b1 && prev_pdv) || (programming_done === 1'b1 && prev_done))
      back2back_cnt++;
    prev_pdv  = programming_data_valid;
    prev_done = programming_done;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; byte_valid = 1'b0; result_valid = 1'b0; result_passed = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Offers one byte and holds it until taken; a stuck byte_ready is a failure.
  task automatic send_byte(input logic [7:0] b);
    int t;
    @(negedge clk);
    byte_in = b; byte_valid = 1'b1;
    t = 0;
    while (byte_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("byte_accept_timeout", 64'(t), 64'(0));
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int k = 0; k < 4; k++) begin
      if (max_gap > 0) idle($urandom_range(0, max_gap));
      send_byte(w[8*k +: 8]);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_byte_ready"}, 64'(byte_ready), 64'(1));
    check({tag, "_inst"}, 64'(inst), 64'(0));
    check({tag, "_offset"}, 64'(inst_mem_offset), 64'(0));
    check({tag, "_pdv"}, 64'(programming_data_valid), 64'(0));
    check({tag, "_done"}, 64'(programming_done), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_load_error"}, 64'(load_error), 64'(0));
    check({tag, "_status_valid"}, 64'(status_valid), 64'(0));
    check({tag, "_status_pass"}, 64'(status_pass), 64'(0));
  endtask

  logic [31:0] basic_words[3];
  logic [31:0] gap_words[2];
  int          wb;
  int          db;
  int          bad;
  logic [31:0] w;

  initial begin
    reset = 1'b1; byte_in = 8'h00; byte_valid = 1'b0;
    result_valid = 1'b0; result_passed = 1'b0;
    basic_words[0] = 32'h0000_0013;
    basic_words[1] = 32'h0010_0093;
    basic_words[2] = 32'hDEAD_BEEF;
    gap_words[0]   = 32'hCAFE_F00D;
    gap_words[1]   = 32'h1234_5678;

    // Reset state.
    do_reset();
    check_reset_values("reset");

    // Basic 3-word load at full rate.
    wb = wr_data.size(); db = done_cnt;
    send_byte(8'h03);
    @(negedge clk);
    check("basic_busy_len_hi", 64'(busy), 64'(1));
    send_byte(8'h00);
    for (int i = 0; i < 3; i++) send_word(basic_words[i], 0);
    idle(4);
    check("basic_write_count", 64'(wr_data.size() - wb), 64'(3));
    if (wr_data.size() - wb == 3) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("basic_data%0d", i), 64'(wr_data[wb+i]), 64'(basic_words[i]));
        check($sformatf("basic_off%0d", i), 64'(wr_off[wb+i]), 64'(i));
      end
      check("basic_spacing01", 64'(wr_cyc[wb+1] - wr_cyc[wb]), 64'(5));
      check("basic_spacing12", 64'(wr_cyc[wb+2] - wr_cyc[wb+1]), 64'(5));
      check("basic_done_latency", 64'(done_cyc - wr_cyc[wb+2]), 64'(1));
    end
    check("basic_done_count", 64'(done_cnt - db), 64'(1));
    check("basic_ready_after", 64'(byte_ready), 64'(0));
    check("basic_busy_after", 64'(busy), 64'(0));

    // Bytes offered in RUN stay on the bus.
    wb = wr_data.size();
    @(negedge clk); byte_in = 8'h55; byte_valid = 1'b1;
    idle(3);
    check("run_ready_low", 64'(byte_ready), 64'(0));
    byte_valid = 1'b0;
    check("run_no_writes", 64'(wr_data.size() - wb), 64'(0));

    // Result capture; second pulse ignored.
    check("status_before", 64'(status_valid), 64'(0));
    result_valid = 1'b1; result_passed = 1'b1;
    @(negedge clk);
    result_valid = 1'b0; result_passed = 1'b0;
    check("status_valid_set", 64'(status_valid), 64'(1));
    check("status_pass_set", 64'(status_pass), 64'(1));
    idle(2);
    result_valid = 1'b1; result_passed = 1'b0;
    @(negedge clk);
    result_valid = 1'b0;
    idle(1);
    check("status_pass_sticky", 64'(status_pass), 64'(1));
    check("status_valid_sticky", 64'(status_valid), 64'(1));

    // Header N=0.
    do_reset();
    check("reset_clears_inst", 64'(inst), 64'(0));
    check("reset_clears_status", 64'(status_valid), 64'(0));
    wb = wr_data.size(); db = done_cnt;
    send_byte(8'h00);
    send_byte(8'h00);
    @(negedge clk);
    check("n0_load_error", 64'(load_error), 64'(1));
    check("n0_ready", 64'(byte_ready), 64'(0));
    check("n0_busy", 64'(busy), 64'(0));
    idle(5);
    check("n0_no_writes", 64'(wr_data.size() - wb), 64'(0));
    check("n0_no_done", 64'(done_cnt - db), 64'(0));

    // Header N=1025.
    do_reset();
    send_byte(8'h01);
    send_byte(8'h04);
    @(negedge clk);
    check("n1025_load_error", 64'(load_error), 64'(1));

    // Header N=1024: full memory.
    do_reset();
    wb = wr_data.size(); db = done_cnt;
    send_byte(8'h00);
    send_byte(8'h04);
    @(negedge clk);
    check("n1024_no_error", 64'(load_error), 64'(0));
    for (int i = 0; i < 1024; i++) begin
      w = (32'(i) << 16) | (32'h0000_FFFF ^ 32'(i));
      send_word(w, 0);
    end
    idle(4);
    check("n1024_write_count", 64'(wr_data.size() - wb), 64'(1024));
    bad = 0;
    if (wr_data.size() - wb == 1024) begin
      for (int i = 0; i < 1024; i++) begin
        w = (32'(i) << 16) | (32'h0000_FFFF ^ 32'(i));
        if (wr_data[wb+i] !== w || wr_off[wb+i] != i) bad++;
      end
      check("n1024_last_offset", 64'(wr_off[wb+1023]), 64'(10'h3FF));
    end
    check("n1024_mismatches", 64'(bad), 64'(0));
    check("n1024_done_count", 64'(done_cnt - db), 64'(1));

    // Two words with random byte gaps.
    do_reset();
    wb = wr_data.size(); db = done_cnt;
    idle($urandom_range(0, 7));
    send_byte(8'h02);
    idle($urandom_range(0, 7));
    send_byte(8'h00);
    for (int i = 0; i < 2; i++) send_word(gap_words[i], 7);
    idle(4);
    check("gap_write_count", 64'(wr_data.size() - wb), 64'(2));
    if (wr_data.size() - wb == 2) begin
      check("gap_data0", 64'(wr_data[wb]), 64'(gap_words[0]));
      check("gap_data1", 64'(wr_data[wb+1]), 64'(gap_words[1]));
      check("gap_off0", 64'(wr_off[wb]), 64'(0));
      check("gap_off1", 64'(wr_off[wb+1]), 64'(1));
    end
    check("gap_done_count", 64'(done_cnt - db), 64'(1));

    // Reset mid-load, then a fresh single-word stream.
    do_reset();
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk);
    check("midload_busy", 64'(busy), 64'(1));
    do_reset();
    check_reset_values("midload_reset");
    wb = wr_data.size(); db = done_cnt;
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(32'hDDCC_BBAA, 0);
    idle(4);
    check("fresh_write_count", 64'(wr_data.size() - wb), 64'(1));
    if (wr_data.size() - wb == 1) begin
      check("fresh_data", 64'(wr_data[wb]), 64'(32'hDDCC_BBAA));
      check("fresh_off", 64'(wr_off[wb]), 64'(0));
      check("fresh_done_latency", 64'(done_cyc - wr_cyc[wb]), 64'(1));
    end
    check("fresh_done_count", 64'(done_cnt - db), 64'(1));

    // Strobe exclusivity over the whole run.
    check("strobe_overlap", 64'(overlap_cnt), 64'(0));
    check("strobe_back_to_back", 64'(back2back_cnt), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
